// File: rtl/tc_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tc_issue_arbiter
//
// Purpose:
//   Round-robin issue arbiter in front of a tensor core. Up to NUM_REQ warps
//   present an operation (opaque payload plus destination register index).
//   One warp at a time is accepted into a single-entry issue register, which
//   drives the tensor core input. Operations in flight are counted and capped
//   at MAX_OUT. Results coming back from the tensor core are routed to the
//   owning warp through the warp-id field of the returned tag. A flush
//   request stops acceptance, waits until everything in flight has returned,
//   and then pulses flush_done_o.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous reset, active HIGH (the name is historical)
//   req_valid      per-warp request valid                      [NUM_REQ]
//   req_ready      per-warp accept strobe, one-hot or zero     [NUM_REQ]
//   req_payload    per-warp payload, warp i at [i*PAYLOAD_W +: PAYLOAD_W]
//   req_idxw       per-warp destination index, warp i at [i*8 +: 8]
//   tc_in_valid    issue valid toward the tensor core
//   tc_in_ready    tensor core accepts the issue
//   tc_in_payload  issued payload
//   tc_in_tag      {idxw, warp id} travelling with the payload
//   tc_out_valid   tensor core result valid
//   tc_out_tag     tag returned with the result
//   tc_out_ready   result may leave the tensor core
//   resp_valid     result valid routed to the owning warp      [NUM_REQ]
//   resp_ready     per-warp result acceptance                  [NUM_REQ]
//   flush_i        stop issuing and drain
//   flush_done_o   single-cycle pulse once the drain is complete
//   outstanding_o  operations accepted but not yet returned
// ---------------------------------------------------------------------------
module tc_issue_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int PAYLOAD_W = 64,
   parameter int MAX_OUT   = 4,
   localparam int WID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNT_W    = $clog2(MAX_OUT + 1),
   localparam int TAG_W    = 8 + WID_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
   input  logic [NUM_REQ*8-1:0]         req_idxw,
   output logic                         tc_in_valid,
   input  logic                         tc_in_ready,
   output logic [PAYLOAD_W-1:0]         tc_in_payload,
   output logic [TAG_W-1:0]             tc_in_tag,
   input  logic                         tc_out_valid,
   input  logic [TAG_W-1:0]             tc_out_tag,
   output logic                         tc_out_ready,
   output logic [NUM_REQ-1:0]           resp_valid,
   input  logic [NUM_REQ-1:0]           resp_ready,
   input  logic                         flush_i,
   output logic                         flush_done_o,
   output logic [CNT_W-1:0]             outstanding_o
);

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                 state_reg, state_next;
   logic                   done_seen_reg, done_seen_next;
   logic                   issue_valid_reg, issue_valid_next;
   logic [PAYLOAD_W-1:0]   issue_payload_reg, issue_payload_next;
   logic [TAG_W-1:0]       issue_tag_reg, issue_tag_next;
   logic [WID_W-1:0]       rr_ptr_reg, rr_ptr_next;
   logic [CNT_W-1:0]       outstanding_reg, outstanding_next;

   // Per-warp views of the flattened request buses.
   logic [PAYLOAD_W-1:0]   pay_arr  [NUM_REQ];
   logic [7:0]             idxw_arr [NUM_REQ];

   logic [WID_W-1:0]       ret_wid;
   logic                   out_hs;
   logic                   out_dec;
   logic                   room;
   logic                   slot_free;
   logic                   accept_en;
   logic                   grant_found;
   logic [WID_W-1:0]       grant_wid;
   logic                   accept;

   // ------------------------------------------------------------------
   // Request unpacking and response routing
   // ------------------------------------------------------------------
   assign ret_wid = tc_out_tag[WID_W-1:0];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_warp
         assign pay_arr[gi]    = req_payload[gi*PAYLOAD_W +: PAYLOAD_W];
         assign idxw_arr[gi]   = req_idxw[gi*8 +: 8];
         assign resp_valid[gi] = tc_out_valid && (ret_wid == WID_W'(gi));
         assign req_ready[gi]  = accept && (grant_wid == WID_W'(gi));
      end
   endgenerate

   // A tag naming a non-existent warp is never handed to anyone.
   always_comb begin
      tc_out_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ret_wid == WID_W'(i)) begin
            tc_out_ready = resp_ready[i];
         end
      end
   end

   assign out_hs  = tc_out_valid && tc_out_ready;
   // Results arriving after a reset belong to nothing we counted.
   assign out_dec = out_hs && (outstanding_reg != '0);

   // ------------------------------------------------------------------
   // Acceptance enable
   // ------------------------------------------------------------------
   // A returning result frees a slot in the same cycle, so a full core can
   // still take a new request when a handshake coincides.
   assign room      = (outstanding_reg < CNT_W'(MAX_OUT)) || out_hs;
   assign slot_free = !issue_valid_reg || tc_in_ready;
   // Reset is folded in so nothing is granted while reset is held.
   assign accept_en = !rst_n && (state_reg == ST_ISSUE) && !flush_i &&
                      slot_free && room;

   // ------------------------------------------------------------------
   // Round-robin search: first requester at or after rr_ptr_reg
   // ------------------------------------------------------------------
   always_comb begin
      logic [WID_W:0] cand;
      grant_found = 1'b0;
      grant_wid   = '0;
      cand        = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = {1'b0, rr_ptr_reg} + (WID_W+1)'(off);
         if (cand >= (WID_W+1)'(NUM_REQ)) begin
            cand = cand - (WID_W+1)'(NUM_REQ);
         end
         if (!grant_found && req_valid[cand[WID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_wid   = cand[WID_W-1:0];
         end
      end
   end

   assign accept = accept_en && grant_found;

   // ------------------------------------------------------------------
   // Issue register, pointer and outstanding counter next-state
   // ------------------------------------------------------------------
   always_comb begin
      issue_valid_next   = issue_valid_reg;
      issue_payload_next = issue_payload_reg;
      issue_tag_next     = issue_tag_reg;
      rr_ptr_next        = rr_ptr_reg;
      outstanding_next   = outstanding_reg;

      if (accept) begin
         issue_valid_next   = 1'b1;
         issue_payload_next = pay_arr[grant_wid];
         issue_tag_next     = {idxw_arr[grant_wid], grant_wid};
         rr_ptr_next        = (grant_wid == WID_W'(NUM_REQ - 1)) ?
                              '0 : grant_wid + WID_W'(1);
      end else if (tc_in_ready) begin
         issue_valid_next   = 1'b0;
      end

      case ({accept, out_dec})
         2'b10:   outstanding_next = outstanding_reg + CNT_W'(1);
         2'b01:   outstanding_next = outstanding_reg - CNT_W'(1);
         default: outstanding_next = outstanding_reg;
      endcase
   end

   // ------------------------------------------------------------------
   // Flush FSM: next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      done_seen_next = 1'b0;
      flush_done_o   = 1'b0;
      case (state_reg)
         ST_ISSUE: begin
            if (flush_i) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((outstanding_reg == '0) && !issue_valid_reg) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            // Pulse only on the first DONE cycle; linger quietly while the
            // flush request is still held.
            done_seen_next = 1'b1;
            flush_done_o   = !done_seen_reg;
            if (!flush_i) begin
               state_next = ST_ISSUE;
            end
         end
         default: begin
            state_next = ST_ISSUE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_reg         <= ST_ISSUE;
         done_seen_reg     <= 1'b0;
         issue_valid_reg   <= 1'b0;
         issue_payload_reg <= '0;
         issue_tag_reg     <= '0;
         rr_ptr_reg        <= '0;
         outstanding_reg   <= '0;
      end else begin
         state_reg         <= state_next;
         done_seen_reg     <= done_seen_next;
         issue_valid_reg   <= issue_valid_next;
         issue_payload_reg <= issue_payload_next;
         issue_tag_reg     <= issue_tag_next;
         rr_ptr_reg        <= rr_ptr_next;
         outstanding_reg   <= outstanding_next;
      end
   end

   assign tc_in_valid   = issue_valid_reg;
   assign tc_in_payload = issue_payload_reg;
   assign tc_in_tag     = issue_tag_reg;
   assign outstanding_o = outstanding_reg;

endmodule

// File: tb/tb_tc_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tc_issue_arbiter
//
// Purpose:
//   Self-checking bench for tc_issue_arbiter (NUM_REQ=4, PAYLOAD_W=64,
//   MAX_OUT=4). A behavioural model tracks the issue slot, the in-flight
//   count, the round-robin pointer and the flush mode with plain integers,
//   and each scenario task compares DUT outputs against it or against
//   hand-derived constants.
// ---------------------------------------------------------------------------
module tb_tc_issue_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int PAYLOAD_W = 64;
   localparam int MAX_OUT   = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [3:0]    req_valid = '0;
   logic [3:0]    req_ready;
   logic [255:0]  req_payload = '0;
   logic [31:0]   req_idxw = '0;
   logic          tc_in_valid;
   logic          tc_in_ready = 1'b0;
   logic [63:0]   tc_in_payload;
   logic [9:0]    tc_in_tag;
   logic          tc_out_valid = 1'b0;
   logic [9:0]    tc_out_tag = '0;
   logic          tc_out_ready;
   logic [3:0]    resp_valid;
   logic [3:0]    resp_ready = '0;
   logic          flush_i = 1'b0;
   logic          flush_done_o;
   logic [2:0]    outstanding_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tc_issue_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .PAYLOAD_W (PAYLOAD_W),
      .MAX_OUT   (MAX_OUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_payload   (req_payload),
      .req_idxw      (req_idxw),
      .tc_in_valid   (tc_in_valid),
      .tc_in_ready   (tc_in_ready),
      .tc_in_payload (tc_in_payload),
      .tc_in_tag     (tc_in_tag),
      .tc_out_valid  (tc_out_valid),
      .tc_out_tag    (tc_out_tag),
      .tc_out_ready  (tc_out_ready),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .flush_i       (flush_i),
      .flush_done_o  (flush_done_o),
      .outstanding_o (outstanding_o)
   );

   // ---------------- behavioural model ----------------
   int          m_mode;      // 0 issuing, 1 draining, 2 drained
   bit          m_pulsed;
   int          m_ptr;
   int          m_out;
   bit          m_iv;
   logic [63:0] m_ipay;
   logic [9:0]  m_itag;

   int          e_win;
   bit          e_hs;
   logic [3:0]  e_req_ready;
   logic [3:0]  e_resp_valid;
   logic        e_tc_out_ready;
   logic        e_done;

   task automatic model_reset();
      m_mode = 0; m_pulsed = 0; m_ptr = 0; m_out = 0;
      m_iv = 0; m_ipay = '0; m_itag = '0;
   endtask

   task automatic model_eval();
      int rw;
      int cand;
      rw             = int'(tc_out_tag[1:0]);
      e_tc_out_ready = resp_ready[tc_out_tag[1:0]];
      e_resp_valid   = tc_out_valid ? 4'(1 << rw) : 4'b0;
      e_hs           = tc_out_valid && e_tc_out_ready;
      e_win          = -1;
      if (m_mode == 0 && !flush_i && (!m_iv || tc_in_ready) &&
          (m_out < MAX_OUT || e_hs)) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = (m_ptr + k) % NUM_REQ;
            if (e_win < 0 && req_valid[2'(cand)]) e_win = cand;
         end
      end
      e_req_ready = (e_win >= 0) ? 4'(1 << e_win) : 4'b0;
      e_done      = (m_mode == 2) && !m_pulsed;
   endtask

   task automatic model_commit();
      int  old_out;
      bit  old_iv;
      old_out = m_out;
      old_iv  = m_iv;
      case (m_mode)
         0: if (flush_i) m_mode = 1;
         1: if (old_out == 0 && !old_iv) begin m_mode = 2; m_pulsed = 0; end
         default: begin m_pulsed = 1; if (!flush_i) m_mode = 0; end
      endcase
      if (e_win >= 0) begin
         m_iv   = 1;
         m_ipay = req_payload[e_win*64 +: 64];
         m_itag = {req_idxw[e_win*8 +: 8], 2'(e_win)};
         m_ptr  = (e_win + 1) % NUM_REQ;
         $display("txn t=%0t accept warp %0d tag %h payload %h out %0d",
                  $time, e_win, m_itag, m_ipay, old_out + 1 - ((e_hs && old_out > 0) ? 1 : 0));
      end else if (tc_in_ready) begin
         m_iv = 0;
      end
      m_out = m_out + ((e_win >= 0) ? 1 : 0) - ((e_hs && old_out > 0) ? 1 : 0);
   endtask

   // Inputs change at the falling edge; outputs are sampled 1 ns later.
   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic rand_payloads();
      for (int w = 0; w < NUM_REQ; w++) begin
         req_payload[w*64 +: 64] = {$urandom, $urandom};
         req_idxw[w*8 +: 8]      = 8'($urandom);
      end
   endtask

   task automatic quiet_inputs();
      req_valid = '0; tc_in_ready = 1'b0; tc_out_valid = 1'b0;
      tc_out_tag = '0; resp_ready = '0; flush_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      quiet_inputs();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      model_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      quiet_inputs();
      req_valid = 4'hF; tc_in_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      n_vec++; if (tc_in_valid !== 1'b0) begin n_err++; $display("FAIL reset_tc_in_valid: got %b want 0", tc_in_valid); end
      n_vec++; if (outstanding_o !== 3'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
      n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      n_vec++; if (flush_done_o !== 1'b0) begin n_err++; $display("FAIL reset_flush_done: got %b want 0", flush_done_o); end
      n_vec++; if (tc_in_payload !== 64'd0 || tc_in_tag !== 10'd0) begin
         n_err++; $display("FAIL reset_payload_tag: got %h/%h want 0/0", tc_in_payload, tc_in_tag);
      end
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      model_reset();
   endtask

   task automatic test_round_robin();
      int prev;
      do_reset();
      req_valid = 4'hF; tc_in_ready = 1'b1; resp_ready = 4'hF;
      prev = -1;
      for (int c = 0; c < 12; c++) begin
         rand_payloads();
         tc_out_valid = (m_out > 0);
         tc_out_tag   = {8'($urandom), 2'($urandom)};
         settle();
         n_vec++; if (req_ready !== 4'(1 << (c % 4))) begin
            n_err++; $display("FAIL rr_order c=%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4)));
         end
         n_vec++; if (req_ready !== e_req_ready) begin
            n_err++; $display("FAIL rr_model c=%0d: got %b want %b", c, req_ready, e_req_ready);
         end
         if (prev >= 0) begin
            n_vec++; if (tc_in_valid !== 1'b1 || tc_in_tag[1:0] !== 2'(prev)) begin
               n_err++; $display("FAIL rr_tag c=%0d: got v=%b wid=%0d want v=1 wid=%0d", c, tc_in_valid, tc_in_tag[1:0], prev);
            end
         end
         prev = c % 4;
         tick();
      end
   endtask

   task automatic test_hold();
      logic [63:0] cap_pay;
      logic [9:0]  cap_tag;
      do_reset();
      req_valid = 4'b0100; tc_in_ready = 1'b0; resp_ready = 4'hF;
      rand_payloads();
      settle();
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL hold_first_grant: got %b want 0100", req_ready); end
      cap_pay = req_payload[2*64 +: 64];
      cap_tag = {req_idxw[2*8 +: 8], 2'd2};
      tick();
      for (int c = 0; c < 3; c++) begin
         rand_payloads();
         settle();
         n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL hold_no_grant c=%0d: got %b want 0000", c, req_ready); end
         n_vec++; if (tc_in_valid !== 1'b1 || tc_in_payload !== cap_pay || tc_in_tag !== cap_tag) begin
            n_err++; $display("FAIL hold_stable c=%0d: got v=%b %h/%h want v=1 %h/%h", c, tc_in_valid, tc_in_payload, tc_in_tag, cap_pay, cap_tag);
         end
         tick();
      end
      tc_in_ready = 1'b1;
      settle();
      n_vec++; if (req_ready !== 4'b0100 || req_ready !== e_req_ready) begin
         n_err++; $display("FAIL hold_release: got %b want 0100", req_ready);
      end
      n_vec++; if (tc_in_payload !== cap_pay || tc_in_tag !== cap_tag) begin
         n_err++; $display("FAIL hold_release_data: got %h/%h want %h/%h", tc_in_payload, tc_in_tag, cap_pay, cap_tag);
      end
      tick();
      req_valid = '0;
      settle();
      tick();
   endtask

   task automatic test_out_limit();
      int acc;
      do_reset();
      req_valid = 4'hF; tc_in_ready = 1'b1; resp_ready = 4'hF;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         rand_payloads();
         settle();
         if (req_ready != 4'b0) acc++;
         n_vec++; if (req_ready !== e_req_ready) begin
            n_err++; $display("FAIL limit_model c=%0d: got %b want %b", c, req_ready, e_req_ready);
         end
         tick();
      end
      settle();
      n_vec++; if (acc != 4) begin n_err++; $display("FAIL limit_accepts: got %0d want 4", acc); end
      n_vec++; if (outstanding_o !== 3'd4) begin n_err++; $display("FAIL limit_outstanding: got %0d want 4", outstanding_o); end
      n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL limit_blocked: got %b want 0000", req_ready); end
      tc_out_valid = 1'b1; tc_out_tag = {8'h11, 2'd1};
      settle();
      n_vec++; if (req_ready !== 4'b0001) begin
         n_err++; $display("FAIL limit_same_cycle: got %b want 0001", req_ready);
      end
      tick();
      tc_out_valid = 1'b0;
      settle();
      n_vec++; if (outstanding_o !== 3'd4) begin n_err++; $display("FAIL limit_hold_at_max: got %0d want 4", outstanding_o); end
   endtask

   // Runs straight after test_out_limit with four operations in flight.
   task automatic test_resp_route();
      req_valid = '0;
      tc_out_valid = 1'b1; tc_out_tag = {8'h5A, 2'd3}; resp_ready = 4'b0111;
      settle();
      n_vec++; if (resp_valid !== 4'b1000) begin n_err++; $display("FAIL route_resp_valid: got %b want 1000", resp_valid); end
      n_vec++; if (tc_out_ready !== 1'b0) begin n_err++; $display("FAIL route_blocked: got %b want 0", tc_out_ready); end
      tick();
      resp_ready = 4'hF;
      settle();
      n_vec++; if (tc_out_ready !== 1'b1) begin n_err++; $display("FAIL route_ready: got %b want 1", tc_out_ready); end
      n_vec++; if (outstanding_o !== 3'd4) begin n_err++; $display("FAIL route_pre_count: got %0d want 4", outstanding_o); end
      tick();
      tc_out_valid = 1'b0;
      settle();
      n_vec++; if (outstanding_o !== 3'd3) begin n_err++; $display("FAIL route_decrement: got %0d want 3", outstanding_o); end
   endtask

   task automatic test_flush();
      int pulses;
      do_reset();
      req_valid = 4'b0011; tc_in_ready = 1'b1; resp_ready = 4'hF;
      rand_payloads();
      settle(); tick();
      settle(); tick();
      req_valid = '0;
      settle(); tick();
      settle();
      n_vec++; if (outstanding_o !== 3'd2 || tc_in_valid !== 1'b0) begin
         n_err++; $display("FAIL flush_setup: got out=%0d v=%b want out=2 v=0", outstanding_o, tc_in_valid);
      end
      flush_i = 1'b1; req_valid = 4'hF;
      settle();
      n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL flush_no_grant: got %b want 0000", req_ready); end
      tick();
      tc_out_valid = 1'b1; tc_out_tag = {8'h00, 2'd0};
      for (int c = 0; c < 2; c++) begin
         settle();
         n_vec++; if (req_ready !== 4'b0 || flush_done_o !== 1'b0) begin
            n_err++; $display("FAIL flush_drain c=%0d: got rr=%b done=%b want 0000/0", c, req_ready, flush_done_o);
         end
         tick();
      end
      tc_out_valid = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         settle();
         if (flush_done_o === 1'b1) pulses++;
         n_vec++; if (flush_done_o !== e_done) begin
            n_err++; $display("FAIL flush_done_model c=%0d: got %b want %b", c, flush_done_o, e_done);
         end
         tick();
      end
      n_vec++; if (pulses != 1) begin n_err++; $display("FAIL flush_done_pulses: got %0d want 1", pulses); end
      flush_i = 1'b0;
      settle(); tick();
      settle();
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL flush_resume_ptr: got %b want 0100", req_ready); end
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      req_valid = 4'hF; tc_in_ready = 1'b1; resp_ready = 4'hF;
      for (int c = 0; c < 3; c++) begin
         rand_payloads(); settle(); tick();
      end
      req_valid = '0; tc_in_ready = 1'b0;
      settle();
      n_vec++; if (outstanding_o !== 3'd3 || tc_in_valid !== 1'b1) begin
         n_err++; $display("FAIL areset_setup: got out=%0d v=%b want out=3 v=1", outstanding_o, tc_in_valid);
      end
      #2 rst_n = 1'b1;
      #1;
      n_vec++; if (tc_in_valid !== 1'b0 || outstanding_o !== 3'd0) begin
         n_err++; $display("FAIL areset_immediate: got v=%b out=%0d want v=0 out=0", tc_in_valid, outstanding_o);
      end
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      req_valid = 4'hF; tc_in_ready = 1'b1;
      settle();
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL areset_ptr: got %b want 0001", req_ready); end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rand_payloads();
         req_valid    = 4'($urandom);
         tc_in_ready  = ($urandom % 4) != 0;
         tc_out_valid = ($urandom % 2) != 0;
         tc_out_tag   = 10'($urandom);
         resp_ready   = 4'($urandom);
         if ($urandom % 40 == 0) flush_i = ~flush_i;
         settle();
         n_vec++; if (req_ready !== e_req_ready) begin
            n_err++; $display("FAIL rand_req_ready c=%0d: got %b want %b", c, req_ready, e_req_ready);
         end
         n_vec++; if (tc_in_valid !== m_iv || (m_iv && (tc_in_payload !== m_ipay || tc_in_tag !== m_itag))) begin
            n_err++; $display("FAIL rand_issue c=%0d: got v=%b %h/%h want v=%b %h/%h", c, tc_in_valid, tc_in_payload, tc_in_tag, m_iv, m_ipay, m_itag);
         end
         n_vec++; if (resp_valid !== e_resp_valid || tc_out_ready !== e_tc_out_ready) begin
            n_err++; $display("FAIL rand_route c=%0d: got %b/%b want %b/%b", c, resp_valid, tc_out_ready, e_resp_valid, e_tc_out_ready);
         end
         n_vec++; if (outstanding_o !== 3'(m_out) || flush_done_o !== e_done) begin
            n_err++; $display("FAIL rand_count_done c=%0d: got %0d/%b want %0d/%b", c, outstanding_o, flush_done_o, m_out, e_done);
         end
         tick();
      end
      flush_i = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_round_robin();
      test_hold();
      test_out_limit();
      test_resp_route();
      test_flush();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tc_issue_arbiter.md
TC_ISSUE_ARBITER -- requirements
Module: tc_issue_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of warp requesters; warp id width WID_W = clog2(NUM_REQ) = 2.
REQ-002 Parameter PAYLOAD_W, default 64: opaque operation payload width (operand handles, type_ab/type_cd, rm) passed through unmodified.
REQ-003 Parameter MAX_OUT, default 4: maximum operations outstanding in the tensor core.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  NUM_REQ  per-warp request valid.
REQ-007 req_ready  out  NUM_REQ  per-warp request accepted this cycle; at most one bit set.
REQ-008 req_payload  in  NUM_REQ*PAYLOAD_W  per-warp payload; warp i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
REQ-009 req_idxw  in  NUM_REQ*8  per-warp destination register index; warp i at [i*8 +: 8].
REQ-010 tc_in_valid  out  1  issue valid to tensor core.
REQ-011 tc_in_ready  in  1  tensor core accepts issue.
REQ-012 tc_in_payload  out  PAYLOAD_W  issued payload.
REQ-013 tc_in_tag  out  8+WID_W  {idxw, warp id} issued with the payload.
REQ-014 tc_out_valid  in  1  tensor core result valid.
REQ-015 tc_out_tag  in  8+WID_W  tag returned with the result.
REQ-016 tc_out_ready  out  1  result may leave the tensor core.
REQ-017 resp_valid  out  NUM_REQ  result valid routed to the owning warp.
REQ-018 resp_ready  in  NUM_REQ  per-warp result acceptance.
REQ-019 flush_i  in  1  request to stop issuing and drain.
REQ-020 flush_done_o  out  1  one-cycle pulse when drain complete.
REQ-021 outstanding_o  out  clog2(MAX_OUT+1)  current outstanding count.

Function
REQ-022 Issue stage is a single output register (payload, tag, valid); a request accepted in cycle N drives tc_in_valid in cycle N+1.
REQ-023 tc_in_valid, tc_in_payload, tc_in_tag are held stable until tc_in_ready is sampled high.
REQ-024 Acceptance enable = state ISSUE, and (issue register empty or tc_in_ready), and (outstanding < MAX_OUT or a tc_out handshake occurs this cycle).
REQ-025 When enabled, req_ready goes to the first requesting warp at or after the round-robin pointer, wrapping modulo NUM_REQ; req_ready is all-zero otherwise.
REQ-026 Round-robin pointer becomes winner+1 (mod NUM_REQ) after each acceptance; unchanged in cycles without acceptance.
REQ-027 outstanding increments on request acceptance and decrements on tc_out handshake (tc_out_valid and tc_out_ready); both in one cycle leaves it unchanged; never exceeds MAX_OUT nor underflows.
REQ-028 Response routing is combinational: resp_valid[w] = tc_out_valid and tag warp field == w; tc_out_ready = resp_ready[tag warp field].
REQ-029 States: ISSUE, DRAIN, DONE; ISSUE->DRAIN when flush_i high (no acceptance in that cycle or after); DRAIN->DONE when outstanding == 0 and issue register empty; DONE asserts flush_done_o for exactly one cycle and returns to ISSUE when flush_i low, else stays in DONE with flush_done_o low.
REQ-030 Results arriving in DRAIN are routed normally; the issue register continues to drain to the tensor core in DRAIN.

Reset
REQ-031 While rst_n high: state ISSUE, issue register empty, tc_in_valid 0, pointer 0, outstanding 0, req_ready 0, flush_done_o 0; payload/tag registers cleared to 0.
REQ-032 Reset mid-operation discards the issue register and outstanding count immediately; in-flight tensor-core results are not tracked after reset.

Verification
REQ-033 Warps 0..3 all valid continuously, tc_in_ready=1, results returned each cycle -> grant order 0,1,2,3,0,... one per cycle, tc_in_tag warp field matches.
REQ-034 Warp 2 only, tc_in_ready=0 for 3 cycles -> one acceptance, tc_in_valid held with payload/tag unchanged, no further req_ready until tc_in_ready=1.
REQ-035 No results returned, continuous requests -> exactly 4 acceptances, outstanding_o=4, req_ready 0; one tc_out handshake -> acceptance in that same cycle, outstanding stays 4.
REQ-036 tc_out_tag warp=3, resp_ready[3]=0 -> resp_valid=4'b1000, tc_out_ready=0; resp_ready[3]=1 -> handshake, outstanding decrements by 1.
REQ-037 outstanding=2, flush_i=1 with warps requesting -> no req_ready; after two results, flush_done_o pulses one cycle; flush_i low -> granting resumes at saved pointer.
REQ-038 rst_n high with outstanding=3 and issue register full -> tc_in_valid 0, outstanding_o 0 asynchronously, pointer 0 after release.
